// File: rtl/pulse_stretch_out_if.sv
// Trigger/status bundle for the one-shot output pulse driver.
// Game logic drives trig (master); the stretcher drives the rest (slave).
interface pulse_stretch_out_if;
    logic trig;
    logic out;
    logic busy;
    logic pending;
    logic drop;

    modport master (
        output trig,
        input  out,
        input  busy,
        input  pending,
        input  drop
    );

    modport slave (
        input  trig,
        output out,
        output busy,
        output pending,
        output drop
    );
endinterface

// File: rtl/pulse_stretch_out.sv
// One-shot pulse stretcher: fixed HOLD high time, enforced GAP, one-deep queue.
// PULSE_RETRIGGER_EN: trig during HOLD extends the pulse instead of queueing.
module pulse_stretch_out #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 16,
    parameter int CNT_W       = 6
) (
    input  logic                clk,
    input  logic                n_rst,
    pulse_stretch_out_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pending, pend_n;
    logic             drop, drop_n;
    logic             req_busy;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pend_n;
            drop    <= drop_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pend_n   = pending;
        drop_n   = 1'b0;
        req_busy = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.trig) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LD;
                end
            end
            HOLD: begin
`ifdef PULSE_RETRIGGER_EN
                if (bus.trig) begin
                    cnt_n = HOLD_LD;
                end else if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - ONE;
                end
`else
                req_busy = bus.trig;
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - ONE;
                end
`endif
            end
            GAP: begin
                if (cnt == '0) begin
                    // Queued request goes first; a fresh trig takes its slot.
                    if (pending || bus.trig) begin
                        state_n = HOLD;
                        cnt_n   = HOLD_LD;
                        pend_n  = pending && bus.trig;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n    = cnt - ONE;
                    req_busy = bus.trig;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (req_busy) begin
            if (pending) begin
                drop_n = 1'b1;
            end else begin
                pend_n = 1'b1;
            end
        end
    end

    assign bus.out     = (state == HOLD);
    assign bus.busy    = (state != IDLE);
    assign bus.pending = pending;
    assign bus.drop    = drop;
endmodule

// File: tb/tb_pulse_stretch_out.sv
// Bench for pulse_stretch_out: interval-based model checked every cycle,
// plus literal expectations taken from the directed scenarios.
module tb_pulse_stretch_out;
    localparam int H = 4;
    localparam int G = 3;
`ifdef PULSE_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk;
    logic n_rst;
    pulse_stretch_out_if ifc ();

    pulse_stretch_out #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .CNT_W      (6)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: got %b want %b", name, act, req);
        else
            n_pass++;
    endtask

    // Model: the current pulse occupies cycles s..h high, h+1..e low.
    int mk;
    int s, h, e;
    bit pend;
    logic [3:0] exp_v;

    always @(posedge clk or negedge n_rst) begin
        int k, c;
        bit t, dr, act;
        if (!n_rst) begin
            mk = 0;
            s = -100;
            h = -100;
            e = -100;
            pend = 1'b0;
            exp_v = 4'b0000;
        end else begin
            k = mk;
            t = ifc.trig;
            dr = 1'b0;
            act = (k >= s) && (k <= e);
            if (!act) begin
                if (t) begin
                    s = k + 1; h = s + H - 1; e = h + G;
                end
            end else if (k == e) begin
                if (pend || t) begin
                    s = k + 1; h = s + H - 1; e = h + G;
                    pend = pend && t;
                end
            end else if (RETRIG && k <= h) begin
                if (t) begin
                    h = k + H; e = h + G;
                end
            end else if (t) begin
                if (pend) dr = 1'b1;
                else pend = 1'b1;
            end
            mk = k + 1;
            c = mk;
            exp_v = {(c >= s && c <= h), (c >= s && c <= e), pend, dr};
        end
    end

    logic [3:0] lg [64];

    always @(negedge clk) begin
        logic [3:0] d;
        if (chk_en) begin
            d = {ifc.out, ifc.busy, ifc.pending, ifc.drop};
            if (mk < 64) lg[mk] = d;
            chk($sformatf("cycle%0d", mk), d, exp_v);
        end
    end

    function automatic int pulses(input int n);
        int p = 0;
        for (int i = 1; i < n; i++)
            if (lg[i][3] && !lg[i-1][3]) p++;
        return p;
    endfunction

    function automatic int drops(input int n);
        int p = 0;
        for (int i = 0; i < n; i++)
            if (lg[i][0]) p++;
        return p;
    endfunction

    task automatic do_reset();
        n_rst = 1'b0;
        ifc.trig = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic run(input logic [63:0] m, input int n);
        for (int c = 0; c < n; c++) begin
            ifc.trig = m[c];
            @(posedge clk);
            #1;
        end
        ifc.trig = 1'b0;
    endtask

    initial begin
        logic [63:0] m;
        n_rst = 1'b0;
        ifc.trig = 1'b0;
        #2 chk_en = 1'b1;
        #1 chk("reset", {ifc.out, ifc.busy, ifc.pending, ifc.drop}, 4'b0000);

        // single request
        do_reset();
        m = '0; m[10] = 1'b1;
        run(m, 22);
        chk("t1_out10", {3'b0, lg[10][3]}, 4'd0);
        chk("t1_out11", {3'b0, lg[11][3]}, 4'd1);
        chk("t1_out14", {3'b0, lg[14][3]}, 4'd1);
        chk("t1_out15", {3'b0, lg[15][3]}, 4'd0);
        chk("t1_busy17", {3'b0, lg[17][2]}, 4'd1);
        chk("t1_busy18", {3'b0, lg[18][2]}, 4'd0);

`ifdef PULSE_RETRIGGER_EN
        // retrigger extends HOLD
        do_reset();
        m = '0; m[10] = 1'b1; m[13] = 1'b1;
        run(m, 24);
        chk("t6_out17", {3'b0, lg[17][3]}, 4'd1);
        chk("t6_out18", {3'b0, lg[18][3]}, 4'd0);
        chk("t6_busy20", {3'b0, lg[20][2]}, 4'd1);
        chk("t6_busy21", {3'b0, lg[21][2]}, 4'd0);
        chk("t6_pend15", {3'b0, lg[15][1]}, 4'd0);
        chk("t6_drops", 4'(drops(24)), 4'd0);
`else
        // queued request
        do_reset();
        m = '0; m[10] = 1'b1; m[12] = 1'b1;
        run(m, 26);
        chk("t2_pend12", {3'b0, lg[12][1]}, 4'd0);
        chk("t2_pend13", {3'b0, lg[13][1]}, 4'd1);
        chk("t2_pend18", {3'b0, lg[18][1]}, 4'd0);
        chk("t2_out18", {3'b0, lg[18][3]}, 4'd1);
        chk("t2_out22", {3'b0, lg[22][3]}, 4'd0);
        chk("t2_busy17_18", {2'b0, lg[17][2], lg[18][2]}, 4'b0011);

        // overflow drop
        do_reset();
        m = '0; m[10] = 1'b1; m[12] = 1'b1; m[13] = 1'b1;
        run(m, 28);
        chk("t3_drop13_15", {1'b0, lg[13][0], lg[14][0], lg[15][0]}, 4'b0010);
        chk("t3_pulses", 4'(pulses(28)), 4'd2);

        // trig on GAP-exit edge with a request queued
        do_reset();
        m = '0; m[10] = 1'b1; m[12] = 1'b1; m[17] = 1'b1;
        run(m, 34);
        chk("t4_out18", {3'b0, lg[18][3]}, 4'd1);
        chk("t4_pend18", {3'b0, lg[18][1]}, 4'd1);
        chk("t4_out24_25", {2'b0, lg[24][3], lg[25][3]}, 4'b0001);
        chk("t4_out28_29", {2'b0, lg[28][3], lg[29][3]}, 4'b0010);
        chk("t4_drops", 4'(drops(34)), 4'd0);
        chk("t4_pulses", 4'(pulses(34)), 4'd3);
`endif

        // async reset mid-HOLD with a request queued
        do_reset();
        m = '0; m[10] = 1'b1; m[11] = 1'b1;
        run(m, 12);
        chk("t5_pre", {ifc.out, ifc.busy, ifc.pending, ifc.drop}, RETRIG ? 4'b1100 : 4'b1110);
        #2 n_rst = 1'b0;
        #1 chk("t5_async", {ifc.out, ifc.busy, ifc.pending, ifc.drop}, 4'b0000);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        run('0, 16);
        chk("t5_pulses", 4'(pulses(16)), 4'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pulse_stretch_out.md
Name: pulse_stretch_out

Overview:
- One-shot output driver, the transmit-side counterpart to the button edge detector. Converts single-cycle trigger pulses from game logic into clean, fixed-width output pulses for LEDs or buzzer pins.
- Every output pulse is followed by an enforced low gap.
- One trigger arriving during a pulse or gap is queued. Any further triggers are dropped and flagged.

Parameters:
HOLD_CYCLES, 16, output high time in clk cycles (1..2^CNT_W)
GAP_CYCLES, 16, mandatory low time after each pulse in clk cycles (1..2^CNT_W)
CNT_W, 6, width of the shared down-counter

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
trig  input  1  request pulse, sampled each rising edge; any high cycle is one request
out  output  1  stretched pulse, registered
busy  output  1  high while state is HOLD or GAP
pending  output  1  one queued request held
drop  output  1  one-cycle pulse: request discarded because queue already full

Behaviour:
- Reset (n_rst low, asynchronous): state=IDLE, cnt=0, out=0, busy=0, pending=0, drop=0.
- FSM states: IDLE, HOLD, GAP. out = (state==HOLD). busy = (state!=IDLE). Both are derived from registered state only, with no combinational path from trig.
- IDLE:
  - trig=1 at edge k -> state=HOLD, cnt=HOLD_CYCLES-1.
  - out rises in the cycle after edge k (latency 1).
- HOLD:
  - cnt decrements each edge.
  - At cnt==0 -> state=GAP, cnt=GAP_CYCLES-1.
  - out is high for exactly HOLD_CYCLES cycles.
- GAP:
  - cnt decrements each edge.
  - At cnt==0: if pending or trig -> state=HOLD, cnt=HOLD_CYCLES-1; otherwise -> IDLE.
  - out is low for exactly GAP_CYCLES cycles.
- trig while busy, not on the GAP-exit edge:
  - pending=0 -> pending<=1.
  - pending=1 -> drop<=1 for one cycle; pending stays 1.
- GAP-exit edge with pending and trig interaction:
  - pending=1 and trig=1 -> the queued request starts HOLD; trig becomes the new pending (pending stays 1); no drop.
  - pending=1 and trig=0 -> pending<=0.
  - pending=0 and trig=1 -> trig starts HOLD directly; pending stays 0.
- trig on the HOLD->GAP transition edge is treated as an ordinary busy-state request.
- drop is registered and defaults to 0 every cycle it is not asserted.
- Counter never wraps. cnt is only loaded with HOLD_CYCLES-1 or GAP_CYCLES-1 and only decremented from nonzero values.
- HOLD_CYCLES=1 or GAP_CYCLES=1 is legal: the state lasts exactly one cycle.
- Reset asserted mid-pulse: out drops immediately (asynchronous) and any pending request is lost.
- Output pulse count never exceeds accepted requests. Every request is accounted for exactly once: pulsed or dropped.

Optional Feature:
- Macro: PULSE_RETRIGGER_EN.
- Defined: trig during HOLD reloads cnt=HOLD_CYCLES-1, extending the current pulse; it does not set pending and does not drop. Behaviour during GAP is unchanged (queue/drop).
- Undefined: behaviour exactly as specified above; HOLD is never extended.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=3 unless noted):
1. Reset, then single trig at cycle 10 -> out high cycles 11-14, low from 15, busy high cycles 11-17, IDLE at 18; pending=0, drop=0 throughout.
2. trig at cycle 10 and again at cycle 12 -> pending=1 from 13. First pulse cycles 11-14, second pulse cycles 18-21 with no IDLE between; pending clears at 18.
3. trig at cycles 10, 12, 13 -> drop high in cycle 14 only; exactly two output pulses.
4. trig at 10, 12, and 17 (GAP-exit edge) -> second pulse starts 18, pending remains 1, third pulse at 25-28; no drop.
5. n_rst low at cycle 12 during HOLD with pending=1 -> out, busy, pending low at once; no pulse after release until new trig.
6. PULSE_RETRIGGER_EN defined: trig at 10 and 13 -> out high cycles 11-17 (7 cycles), then GAP 18-20; pending=0; drop never asserted.
